// File: rtl/mem_bus_router_pkg.sv
// Shared types and default address map for the cpu memory bus router.
package mem_bus_router_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } bus_state_t;

  // Default map: 1 MiB bram window at 0, single uart register at 0x0010_0000.
  localparam logic [31:0] BRAM_BASE = 32'h0000_0000;
  localparam logic [31:0] BRAM_MASK = 32'hFFF0_0000;
  localparam logic [31:0] UART_BASE = 32'h0010_0000;
  localparam logic [31:0] UART_MASK = 32'hFFFF_FFFF;

  function automatic logic addr_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] mask);
    return (addr & mask) == (base & mask);
  endfunction

endpackage

// File: rtl/mem_bus_router_if.sv
// cpu-style memory bus; N>1 gives per-slave valid/ready/rdata lanes with broadcast request fields.
interface mem_bus_router_if #(
  parameter int N = 1
) ();
  logic [N-1:0]    valid;
  logic            instr;
  logic [31:0]     addr;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic [32*N-1:0] rdata;
  logic [N-1:0]    ready;

  modport master (output valid, instr, addr, wdata, wstrb, input rdata, ready);
  modport slave  (input valid, instr, addr, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/mem_bus_router_decode.sv
// Base/mask address decoder: lowest-index hit wins, otherwise falls back to DEFAULT_SLV.
module mem_bus_decode
  import mem_bus_router_pkg::*;
#(
  parameter int                    NUM_SLV     = 4,
  parameter logic [NUM_SLV*32-1:0] SLV_BASE    = {NUM_SLV{32'h0}},
  parameter logic [NUM_SLV*32-1:0] SLV_MASK    = {NUM_SLV{32'h0}},
  parameter int                    DEFAULT_SLV = 0,
  parameter int                    SEL_W       = 1
) (
  input  logic [31:0]      addr,
  output logic             hit,
  output logic [SEL_W-1:0] sel
);

  localparam logic DEFAULT_OK = (DEFAULT_SLV < NUM_SLV) ? 1'b1 : 1'b0;

  logic [NUM_SLV-1:0] match;
  logic               found;

  // Scan high to low so the lowest matching index is the one left in sel.
  always_comb begin
    found = 1'b0;
    sel   = SEL_W'(DEFAULT_SLV);
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      match[i] = addr_hit(addr, SLV_BASE[32*i +: 32], SLV_MASK[32*i +: 32]);
      found    = found | match[i];
      sel      = match[i] ? SEL_W'(i) : sel;
    end
    hit = found | DEFAULT_OK;
  end

endmodule

// File: rtl/mem_bus_router.sv
// 1-master / NUM_SLV-slave memory bus router with decode-error responses.
// Optional response timeout enabled by defining BUS_TIMEOUT_EN.
module mem_bus_router
  import mem_bus_router_pkg::*;
#(
  parameter int                    NUM_SLV     = 4,
  parameter logic [NUM_SLV*32-1:0] SLV_BASE    = {NUM_SLV{32'h0}},
  parameter logic [NUM_SLV*32-1:0] SLV_MASK    = {NUM_SLV{32'h0}},
  parameter int                    DEFAULT_SLV = 0,
  parameter int                    TIMEOUT_CYC = 1023
) (
  input  logic                    clk,
  input  logic                    rst,
  mem_bus_router_if.slave         cpu,
  mem_bus_router_if.master        slv,
  input  logic                    err_clr,
  output logic                    bus_err,
  output logic [31:0]             err_addr
);

  localparam int SEL_W = $clog2(NUM_SLV + 1);

  bus_state_t         state;
  logic [SEL_W-1:0]   sel;
  logic [31:0]        req_addr;
  logic               dec_hit;
  logic [SEL_W-1:0]   dec_sel;
  logic               accept;
  logic               dec_err;
  logic               tmo_expire;
  logic               rsp_ready;
  logic [31:0]        rsp_rdata;
  logic [NUM_SLV-1:0] valid_vec;

  mem_bus_decode #(
    .NUM_SLV     (NUM_SLV),
    .SLV_BASE    (SLV_BASE),
    .SLV_MASK    (SLV_MASK),
    .DEFAULT_SLV (DEFAULT_SLV),
    .SEL_W       (SEL_W)
  ) u_decode (
    .addr (cpu.addr),
    .hit  (dec_hit),
    .sel  (dec_sel)
  );

  assign accept  = (state == IDLE) && cpu.valid[0] && dec_hit;
  assign dec_err = (state == IDLE) && cpu.valid[0] && !dec_hit;

  // Response and request steering as AND-OR muxes over the slave lanes.
  always_comb begin
    rsp_ready = 1'b0;
    rsp_rdata = 32'h0;
    valid_vec = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      rsp_ready    = rsp_ready | ((state == BUSY) && (sel == SEL_W'(i)) && slv.ready[i]);
      rsp_rdata    = rsp_rdata | ({32{sel == SEL_W'(i)}} & slv.rdata[32*i +: 32]);
      valid_vec[i] = accept && (dec_sel == SEL_W'(i));
    end
  end

  assign slv.valid  = valid_vec;
  assign slv.instr  = cpu.instr;
  assign slv.addr   = cpu.addr;
  assign slv.wdata  = cpu.wdata;
  assign slv.wstrb  = cpu.wstrb;
  assign cpu.ready  = rsp_ready | (state == ERR);
  assign cpu.rdata  = rsp_ready ? rsp_rdata : 32'h0;

`ifdef BUS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Counts BUSY cycles that pass without the selected slave answering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (accept) begin
      tmo_cnt <= '0;
    end else if ((state == BUSY) && !rsp_ready) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end else begin
      tmo_cnt <= tmo_cnt;
    end
  end

  assign tmo_expire = (state == BUSY) && !rsp_ready && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
`else
  assign tmo_expire = 1'b0;
`endif

  // Transaction FSM; a ready arriving in the expiry cycle beats the timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= '0;
      req_addr <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= BUSY;
            sel      <= dec_sel;
            req_addr <= cpu.addr;
          end else if (dec_err) begin
            state <= ERR;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (rsp_ready) begin
            state <= IDLE;
          end else if (tmo_expire) begin
            state <= ERR;
          end else begin
            state <= BUSY;
          end
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky error flag; a new error in the clearing cycle keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_err  <= 1'b0;
      err_addr <= 32'h0;
    end else if (dec_err) begin
      bus_err  <= 1'b1;
      err_addr <= cpu.addr;
    end else if (tmo_expire) begin
      bus_err  <= 1'b1;
      err_addr <= req_addr;
    end else if (err_clr) begin
      bus_err  <= 1'b0;
      err_addr <= err_addr;
    end else begin
      bus_err  <= bus_err;
      err_addr <= err_addr;
    end
  end

endmodule
